// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IFU (read-only) and LSU (load/store) share a single
// memory port with at most one transaction outstanding.
// Optional build macro ARB_LSU_PRIO_EN: fixed priority with LSU winning ties;
// when undefined, ties are resolved round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MaskW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            r_state;
  logic              r_owner;  // 1 = LSU owns the transaction
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MaskW-1:0]  r_wmask;

  logic w_any_req;
  logic w_grant_lsu;
  logic w_accept;
  logic w_in_req;
  logic w_rsp;

  assign w_any_req = ifu_req_valid | lsu_req_valid;

`ifdef ARB_LSU_PRIO_EN
  // LSU wins any tie; IFU only gets the port when LSU is quiet.
  assign w_grant_lsu = lsu_req_valid;
`else
  logic r_last_grant;  // 1 = LSU was granted last
  // LSU wins when alone, or on a tie when IFU was granted last.
  assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | ~r_last_grant);
`endif

  // Readies are gated by rst_n so every output is 0 while reset is held.
  assign w_accept      = rst_n & (r_state == StIdle) & w_any_req;
  assign ifu_req_ready = w_accept & ~w_grant_lsu;
  assign lsu_req_ready = w_accept & w_grant_lsu;

  // Memory request fields are only visible while the request is presented.
  assign w_in_req      = (r_state == StReq);
  assign mem_req_valid = w_in_req;
  assign mem_addr      = w_in_req ? r_addr  : '0;
  assign mem_wen       = w_in_req & r_wen;
  assign mem_wdata     = w_in_req ? r_wdata : '0;
  assign mem_wmask     = w_in_req ? r_wmask : '0;

  // Responses pass straight through to the owner while waiting.
  assign w_rsp         = (r_state == StWait) & mem_rsp_valid;
  assign ifu_rsp_valid = w_rsp & ~r_owner;
  assign lsu_rsp_valid = w_rsp & r_owner;
  assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
  assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;

  // Transaction FSM: latch the winner in idle, present it, wait for response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
`ifndef ARB_LSU_PRIO_EN
      r_last_grant <= 1'b1;  // IFU wins the first tie
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner      <= w_grant_lsu;
            r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_wen        <= w_grant_lsu & lsu_wen;
            r_wdata      <= w_grant_lsu ? lsu_wdata : '0;
            r_wmask      <= w_grant_lsu ? lsu_wmask : '0;
`ifndef ARB_LSU_PRIO_EN
            r_last_grant <= w_grant_lsu;
`endif
            r_state      <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) r_state <= StWait;
        end
        StWait: begin
          if (mem_rsp_valid) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic          owner;  // 1 = LSU
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sampling point: opposite edge.
  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ifu_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_lsu_valid", {63'd0, lsu_rsp_valid}, {63'd0, e.owner});
        chk("rsp_ifu_valid", {63'd0, ifu_rsp_valid}, {63'd0, ~e.owner});
        chk("rsp_data", e.owner ? lsu_rdata : ifu_rdata, e.data);
      end
    end
  end

  // Watchdog against an unexpected hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_lsu;
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

    // Reset held with activity on the inputs: outputs stay 0.
    cyc();
    ifu_req_valid = 1'b1; mem_rsp_valid = 1'b1;
    smp();
    chk("rst_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
    chk("rst_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_ifu_rsp", {63'd0, ifu_rsp_valid}, 64'd0);

    // IFU fetch: accept c0, request c1, response c2.
    cyc();
    rst_n = 1'b1; mem_rsp_valid = 1'b0;
    ifu_addr = 64'h8000_0000; mem_req_ready = 1'b1;
    smp();
    chk("fetch_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
    chk("fetch_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    cyc();
    ifu_req_valid = 1'b0;
    smp();
    chk("fetch_mem_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("fetch_mem_addr", mem_addr, 64'h8000_0000);
    chk("fetch_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("fetch_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    cyc();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h13;
    q.push_back('{owner: 1'b0, data: 64'h13});
    smp();
    chk("fetch_ifu_rsp", {63'd0, ifu_rsp_valid}, 64'd1);

    // Back in idle: memory pulses a stray response, nothing comes out.
    cyc();
    mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD;
    smp();
    chk("idle_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("idle_mem_addr", mem_addr, 64'd0);
    chk("idle_stray_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);

    // LSU store stalled by mem_req_ready=0 for 3 cycles; stray pulse in REQ.
    cyc();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    smp();
    chk("store_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
    chk("store_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      lsu_req_valid = 1'b0; lsu_wdata = '0; lsu_addr = '0; lsu_wmask = '0;
      mem_rsp_valid = (i == 1);
      smp();
      chk("stall_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("stall_mem_addr", mem_addr, 64'h8000_1000);
      chk("stall_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("stall_mem_wmask", {56'd0, mem_wmask}, 64'h0F);
      chk("stall_mem_wen", {63'd0, mem_wen}, 64'd1);
      chk("stall_no_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    end
    cyc();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("store_hs_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("store_hs_wdata", mem_wdata, 64'hDEAD_BEEF);
    cyc();
    mem_req_ready = 1'b0;
    smp();
    chk("wait_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("wait_no_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    cyc();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h55;
    q.push_back('{owner: 1'b1, data: 64'h55});
    smp();
    chk("store_ack_lsu", {63'd0, lsu_rsp_valid}, 64'd1);
    chk("store_ack_ifu", {63'd0, ifu_rsp_valid}, 64'd0);

    // Fresh reset, then both requesters valid continuously.
    cyc();
    mem_rsp_valid = 1'b0; rst_n = 1'b0;
    smp();
    cyc();
    rst_n = 1'b1; mem_req_ready = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h1000;
    lsu_req_valid = 1'b1; lsu_addr = 64'h2000; lsu_wen = 1'b0;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_LSU_PRIO_EN
      exp_lsu = 1'b1;
`else
      exp_lsu = (g % 2 == 1);
`endif
      smp();
      chk("tie_ifu_ready", {63'd0, ifu_req_ready}, {63'd0, ~exp_lsu});
      chk("tie_lsu_ready", {63'd0, lsu_req_ready}, {63'd0, exp_lsu});
      cyc();
      smp();
      chk("tie_mem_addr", mem_addr, exp_lsu ? 64'h2000 : 64'h1000);
      chk("tie_busy_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      cyc();
      mem_rsp_valid = 1'b1; mem_rdata = 64'h100 + 64'(g);
      q.push_back('{owner: exp_lsu, data: 64'h100 + 64'(g)});
      smp();
      cyc();
      mem_rsp_valid = 1'b0;
      if (g == 3) begin
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
    end

    // LSU alone is granted; reset lands while waiting for its response.
    lsu_req_valid = 1'b1; lsu_addr = 64'h3000;
    smp();
    chk("solo_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
    cyc();
    lsu_req_valid = 1'b0;
    smp();
    chk("solo_mem_addr", mem_addr, 64'h3000);
    cyc();
    rst_n = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h77;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    smp();
    chk("midrst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    chk("midrst_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    chk("midrst_rdata", ifu_rdata | lsu_rdata, 64'd0);
    chk("midrst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("midrst_mem_fields", mem_addr | mem_wdata | {56'd0, mem_wmask} | {63'd0, mem_wen},
        64'd0);
    cyc();
    rst_n = 1'b1; mem_rsp_valid = 1'b0; lsu_req_valid = 1'b0; ifu_addr = 64'h4000;
    smp();
    chk("postrst_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
    cyc();
    ifu_req_valid = 1'b0;
    smp();
    chk("postrst_mem_addr", mem_addr, 64'h4000);
    cyc();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h99;
    q.push_back('{owner: 1'b0, data: 64'h99});
    smp();
    cyc();
    mem_rsp_valid = 1'b0;
    smp();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
